// File: rtl/vtdl_pkg.sv
// Shared defaults and sizing helpers for the vtdl delay line and the FIFO built on it.
package vtdl_pkg;

    localparam int unsigned DEF_WID = 8;
    localparam int unsigned DEF_DEP = 16;

    // Occupancy counter width; the extra bits cover DEP itself plus the optional output stage.
    function automatic int unsigned cnt_width(input int unsigned dep);
        return $clog2(dep) + 2;
    endfunction

endpackage

// File: rtl/vtdl.sv
// Variable tap delay line: shifts d in at tap 0 on ce, q presents the word at tap a.
module vtdl
    import vtdl_pkg::*;
#(
    parameter int unsigned WID = DEF_WID,
    parameter int unsigned DEP = DEF_DEP
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic [WID-1:0]           d,
    input  logic [$clog2(DEP)-1:0]   a,
    output logic [WID-1:0]           q
);

    logic [DEP-1:0][WID-1:0] sr_q;

    // Storage only, no reset: validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (ce) begin
            sr_q <= {sr_q[DEP-2:0], d};
        end
    end

    assign q = sr_q[a];

endmodule

// File: rtl/vtdl_fifo.sv
// Synchronous FIFO on a vtdl delay line; the oldest stored word sits at tap scnt-1.
// Defining VTDL_FIFO_OREG_EN adds a registered output stage (capacity DEP+1).
module vtdl_fifo
    import vtdl_pkg::*;
#(
    parameter int unsigned WID   = DEF_WID,
    parameter int unsigned DEP   = DEF_DEP,
    parameter int unsigned AFULL = DEP - 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [WID-1:0]            wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [WID-1:0]            rd_data,
    output logic [cnt_width(DEP)-1:0] count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full
);

    localparam int unsigned AW = $clog2(DEP);
    localparam int unsigned SW = AW + 1;
    localparam int unsigned CW = cnt_width(DEP);

    logic [SW-1:0]  scnt_q, scnt_d;
    logic           push, pop, spop;
    logic [AW-1:0]  tap;
    logic [WID-1:0] tap_q;

    assign wr_ready = (scnt_q != SW'(DEP)) & ~flush;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;
    assign tap      = scnt_q[AW-1:0] - AW'(1);

    vtdl #(
        .WID (WID),
        .DEP (DEP)
    ) u_vtdl (
        .clk (clk),
        .ce  (push),
        .d   (wr_data),
        .a   (tap),
        .q   (tap_q)
    );

`ifdef VTDL_FIFO_OREG_EN
    logic           ovalid_q, ovalid_d;
    logic [WID-1:0] oreg_q, oreg_d;

    // Refill the output stage whenever it is empty or being drained this cycle.
    assign spop = (scnt_q != '0) & (~ovalid_q | pop);

    always_comb begin
        ovalid_d = ovalid_q;
        oreg_d   = oreg_q;
        if (flush) begin
            ovalid_d = 1'b0;
            oreg_d   = '0;
        end else if (spop) begin
            ovalid_d = 1'b1;
            oreg_d   = tap_q;
        end else if (pop) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovalid_q <= 1'b0;
            oreg_q   <= '0;
        end else begin
            ovalid_q <= ovalid_d;
            oreg_q   <= oreg_d;
        end
    end

    assign rd_valid = ovalid_q;
    assign rd_data  = oreg_q;
    assign count    = CW'(scnt_q) + CW'(ovalid_q);
`else
    assign spop     = pop;
    assign rd_valid = (scnt_q != '0);
    assign rd_data  = tap_q;
    assign count    = CW'(scnt_q);
`endif

    always_comb begin
        scnt_d = scnt_q;
        if (flush) begin
            scnt_d = '0;
        end else if (push && !spop) begin
            scnt_d = scnt_q + SW'(1);
        end else if (spop && !push) begin
            scnt_d = scnt_q - SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign full        = (scnt_q == SW'(DEP));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AFULL));

endmodule
